// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds,
// overflow/underflow pulses and optional first-word-fall-through reads.
module fifo_sync_flags #(
    parameter int AWIDTH   = 4,
    parameter int DWIDTH   = 4,
    parameter int AF_LEVEL = 2**AWIDTH - 2,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT     = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_en,
    input  logic              read_en,
    input  logic [DWIDTH-1:0] data_in,
    output logic [DWIDTH-1:0] data_out,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AWIDTH:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2**AWIDTH;
    localparam logic [AWIDTH:0] DEPTH_C = DEPTH[AWIDTH:0];
    localparam logic [AWIDTH:0] AF_C    = AF_LEVEL[AWIDTH:0];
    localparam logic [AWIDTH:0] AE_C    = AE_LEVEL[AWIDTH:0];

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [AWIDTH-1:0] wr_ptr;
    logic [AWIDTH-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic [AWIDTH:0]   count_d;

    // Acceptance uses the registered flags, so a simultaneous pop never
    // frees room for a push into a full FIFO (and vice versa when empty).
    assign wr_acc = write_en && !full;
    assign rd_acc = read_en && !empty;

    always_comb begin
        count_d = count;
        if (wr_acc && !rd_acc) begin
            count_d = count + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_d = count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_d;
            full         <= (count_d == DEPTH_C);
            empty        <= (count_d == '0);
            almost_full  <= (count_d >= AF_C);
            almost_empty <= (count_d <= AE_C);
            overflow     <= write_en && full;
            underflow    <= read_en && empty;
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = mem[rd_ptr];
        end else begin : g_reg
            logic [DWIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem[rd_ptr];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule
